// File: rtl/mayo_axil_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_RW_REGS control registers with byte strobes and
// per-register write pulses, followed by NUM_RO_REGS read-only status words.
module mayo_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW_REGS        = 8,
  parameter int NUM_RO_REGS        = 4
) (
  input  logic                                       ACLK,
  input  logic                                       ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]  reg_out,
  output logic [NUM_RW_REGS-1:0]                     wr_pulse,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int NB       = DW / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = AW - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [NUM_RW_REGS-1:0][DW-1:0] r_regs;
  logic [NUM_RW_REGS-1:0]         r_wrPulse;
  logic                           r_awHeld;
  logic                           r_wHeld;
  logic [IDX_W-1:0]               r_awIdx;
  logic [DW-1:0]                  r_wData;
  logic [NB-1:0]                  r_wStrb;
  logic                           r_bValid;
  logic [1:0]                     r_bResp;
  logic                           r_rValid;
  logic [DW-1:0]                  r_rData;
  logic [1:0]                     r_rResp;

  logic [IDX_W-1:0] w_arIdx;
  logic [1:0]       w_wrResp;
  logic [DW-1:0]    w_rdData;
  logic [1:0]       w_rdResp;
  logic             w_awFire;
  logic             w_wFire;
  logic             w_arFire;
  logic             w_commit;
  logic             w_unused;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = !ARESET && !r_awHeld && !r_bValid;
  assign S_AXI_WREADY  = !ARESET && !r_wHeld && !r_bValid;
  assign S_AXI_ARREADY = !ARESET && !r_rValid;

  assign w_awFire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_wFire  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_arFire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit = r_awHeld && r_wHeld;
  assign w_arIdx  = S_AXI_ARADDR[AW-1:ADDR_LSB];

  assign S_AXI_BVALID = r_bValid;
  assign S_AXI_BRESP  = r_bResp;
  assign S_AXI_RVALID = r_rValid;
  assign S_AXI_RDATA  = r_rData;
  assign S_AXI_RRESP  = r_rResp;
  assign reg_out      = r_regs;
  assign wr_pulse     = r_wrPulse;

  always_comb begin
    w_wrResp = RESP_DECERR;
    if (int'(r_awIdx) < NUM_RW_REGS) begin
      w_wrResp = RESP_OKAY;
    end else if (int'(r_awIdx) < NUM_RW_REGS + NUM_RO_REGS) begin
      w_wrResp = RESP_SLVERR;
    end
  end

  always_comb begin
    w_rdData = '0;
    w_rdResp = RESP_DECERR;
    for (int k = 0; k < NUM_RW_REGS; k++) begin
      if (int'(w_arIdx) == k) begin
        w_rdData = r_regs[k];
        w_rdResp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO_REGS; j++) begin
      if (int'(w_arIdx) == NUM_RW_REGS + j) begin
        w_rdData = status_in[j*DW +: DW];
        w_rdResp = RESP_OKAY;
      end
    end
  end

  // AW and W latch independently; the write lands one cycle after both are held.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_regs    <= '0;
      r_wrPulse <= '0;
      r_awHeld  <= 1'b0;
      r_wHeld   <= 1'b0;
      r_awIdx   <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      r_bValid  <= 1'b0;
      r_bResp   <= RESP_OKAY;
    end else begin
      r_wrPulse <= '0;
      if (w_awFire) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= S_AXI_AWADDR[AW-1:ADDR_LSB];
      end
      if (w_wFire) begin
        r_wHeld <= 1'b1;
        r_wData <= S_AXI_WDATA;
        r_wStrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
        r_bValid <= 1'b1;
        r_bResp  <= w_wrResp;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
          if (int'(r_awIdx) == k) begin
            r_wrPulse[k] <= 1'b1;
            for (int b = 0; b < NB; b++) begin
              if (r_wStrb[b]) r_regs[k][b*8 +: 8] <= r_wData[b*8 +: 8];
            end
          end
        end
      end else if (r_bValid && S_AXI_BREADY) begin
        r_bValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rValid <= 1'b0;
      r_rData  <= '0;
      r_rResp  <= RESP_OKAY;
    end else if (w_arFire) begin
      r_rValid <= 1'b1;
      r_rData  <= w_rdData;
      r_rResp  <= w_rdResp;
    end else if (r_rValid && S_AXI_RREADY) begin
      r_rValid <= 1'b0;
    end
  end

endmodule
